// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uartTx between NREQ byte sources.
// The owner keeps the transmitter until it sends TERM_CHAR, reaches MAX_BURST bytes, or stalls.
//
// state | meaning
// IDLE  | no owner; next valid requester chosen round-robin starting at rr_ptr
// OWN   | grant held; owner bytes forwarded whenever uartTx reports empty
module uart_tx_arbiter #(
  parameter int         NREQ         = 4,
  parameter int         MAX_BURST    = 64,
  parameter logic [7:0] TERM_CHAR    = 8'h0A,
  parameter int         IDLE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  input  logic              tx_empty,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt, rr_ptr, rr_nxt, pick_idx;
  logic            pick_found;
  logic [7:0]      burst_cnt, burst_nxt, burst_inc, owner_byte, tx_data_nxt;
  logic [15:0]     stall_cnt, stall_nxt, stall_inc;
  logic [NREQ-1:0] grant_nxt, ready_nxt;
  logic            tx_wr_nxt, busy_nxt, cooldown, owner_valid, send, rel_now;

  // uartTx lowers empty one cycle after wr, so the write cycle itself must not send
  assign cooldown    = tx_wr;
  assign owner_valid = req_valid[owner];

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req_valid[IW'((int'(rr_ptr) + k) % NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    owner_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner == IW'(k)) owner_byte = req_data[8*k +: 8];
    end
  end

  assign burst_inc = burst_cnt + 8'd1;
  assign stall_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
  assign send      = (state == S_OWN) && owner_valid && tx_empty && !cooldown;
  assign rel_now   = (state == S_OWN) &&
                     ((send && (owner_byte == TERM_CHAR || burst_inc == 8'(MAX_BURST))) ||
                      (!owner_valid && stall_inc == 16'(IDLE_TIMEOUT)));

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= '0;
      req_ready <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
      stall_cnt <= stall_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      tx_wr     <= tx_wr_nxt;
      tx_data   <= tx_data_nxt;
      req_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_found) state_nxt = S_OWN;
      S_OWN:   if (rel_now)    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    burst_nxt   = burst_cnt;
    stall_nxt   = stall_cnt;
    grant_nxt   = grant;
    busy_nxt    = busy;
    tx_wr_nxt   = 1'b0;
    tx_data_nxt = tx_data;
    ready_nxt   = '0;
    case (state)
      S_IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (pick_found) begin
          grant_nxt = NREQ'(1) << pick_idx;
          busy_nxt  = 1'b1;
          owner_nxt = pick_idx;
          burst_nxt = '0;
          stall_nxt = '0;
        end
      end
      S_OWN: begin
        if (send) begin
          tx_wr_nxt   = 1'b1;
          tx_data_nxt = owner_byte;
          ready_nxt   = NREQ'(1) << owner;
          burst_nxt   = burst_inc;
          stall_nxt   = '0;
        end else if (!owner_valid) begin
          stall_nxt = stall_inc;
        end
        if (rel_now) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources per requester, a small uartTx
// empty-flag model, an output log, and one task per scenario.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MAXB = 4;
  localparam int IDLE_TO = 8;
  localparam int CHAR = 8;
  localparam int LOGSZ = 2048;

  logic              clk = 1'b0;
  logic              resn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready, grant;
  logic              tx_wr, busy, tx_empty;
  logic [7:0]        tx_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]      src_mem [NREQ][1024];
  int              src_len [NREQ] = '{default: 0};
  int              src_rd  [NREQ] = '{default: 0};
  logic [NREQ-1:0] hold = '0;
  logic            gaps = 1'b0;
  logic            empty_hold = 1'b0;
  int              ucnt = 0;
  int              cyc = 0;

  logic [7:0]      log_data  [LOGSZ];
  int              log_src   [LOGSZ];
  logic [NREQ-1:0] log_grant [LOGSZ];
  int              log_cyc   [LOGSZ];
  int              log_n = 0;
  logic [NREQ-1:0] glog [LOGSZ];
  int              gcyc [LOGSZ];
  int              gn = 0;
  int              rcyc [LOGSZ];
  int              rn = 0;
  int              consec = 0;
  int              bad_rdy = 0;
  logic            prev_wr = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;
  int              mon_src;

  uart_tx_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAXB), .TERM_CHAR(8'h0A), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .clk(clk), .resn(resn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_empty(tx_empty), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uartTx model: empty drops the cycle after wr and stays low for CHAR cycles
  always @(posedge clk) begin
    if (tx_wr) ucnt <= CHAR;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign tx_empty = !empty_hold && (ucnt == 0);

  // requesters: advance on the ready pulse, present next byte
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) src_rd[i] = src_rd[i] + 1;
      req_valid[i] = !hold[i] && (src_rd[i] < src_len[i]) && !(gaps && $urandom_range(0, 3) == 0);
      req_data[i*8 +: 8] = src_mem[i][src_rd[i] % 1024];
    end
  end

  always @(negedge clk) begin
    mon_src = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_src = i;
    if (tx_wr && log_n < LOGSZ) begin
      log_data[log_n]  = tx_data;
      log_src[log_n]   = mon_src;
      log_grant[log_n] = grant;
      log_cyc[log_n]   = cyc;
      log_n = log_n + 1;
    end
    if (tx_wr && prev_wr) consec = consec + 1;
    if ((tx_wr && $countones(req_ready) != 1) || (!tx_wr && req_ready != '0)) bad_rdy = bad_rdy + 1;
    if (req_ready != '0 && grant != '0 && grant != req_ready) bad_rdy = bad_rdy + 1;
    if (grant != prev_grant) begin
      if (grant != '0 && gn < LOGSZ) begin
        glog[gn] = grant;
        gcyc[gn] = cyc;
        gn = gn + 1;
      end else if (grant == '0 && rn < LOGSZ) begin
        rcyc[rn] = cyc;
        rn = rn + 1;
      end
    end
    prev_wr = tx_wr;
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int r, input logic [7:0] b);
    src_mem[r][src_len[r] % 1024] = b;
    src_len[r] = src_len[r] + 1;
  endtask

  task automatic do_reset();
    resn = 1'b0;
    hold = '0;
    gaps = 1'b0;
    empty_hold = 1'b0;
    repeat (CHAR + 4) tick();
    for (int i = 0; i < NREQ; i++) src_len[i] = src_rd[i];
    tick();
    resn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) load(i, 8'(8'h10 + i));
    repeat (3) tick();
    n_checks++;
    if ({req_ready, grant, tx_wr, tx_data, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b grant=%b wr=%b data=%h busy=%b, want all 0",
               req_ready, grant, tx_wr, tx_data, busy);
    end
    resn = 1'b1;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_grant0: got %b want 0000", grant);
    end
    tick();
    n_checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b busy=%b want 0001/1", grant, busy);
    end
    for (int k = 0; k < 10 && tx_wr !== 1'b1; k++) tick();
    n_checks++;
    if (tx_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_wr: no tx_wr within 10 cycles");
    end
    resn = 1'b0;
    #1;
    n_checks++;
    if ({tx_wr, grant, req_ready, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_midop: wr=%b grant=%b ready=%b busy=%b want 0", tx_wr, grant, req_ready, busy);
    end
  endtask

  task automatic test_message();
    int b;
    logic [7:0] exp [3];
    exp = '{8'h41, 8'h42, 8'h0A};
    do_reset();
    b = log_n;
    for (int i = 0; i < 3; i++) load(0, exp[i]);
    for (int k = 0; k < 100 && log_n < b + 3; k++) tick();
    repeat (3) tick();
    n_checks++;
    if (log_n - b !== 3) begin
      n_fail++;
      $display("FAIL msg_count: got %0d writes want 3", log_n - b);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (log_data[b+i] !== exp[i] || log_src[b+i] !== 0) begin
        n_fail++;
        $display("FAIL msg_byte%0d: got %h from %0d want %h from 0", i, log_data[b+i], log_src[b+i], exp[i]);
      end
    end
    n_checks++;
    if (log_grant[b+1] !== 4'b0001 || log_grant[b+2] !== 4'b0000) begin
      n_fail++;
      $display("FAIL msg_release: grant at 2nd/3rd wr %b/%b want 0001/0000", log_grant[b+1], log_grant[b+2]);
    end
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL msg_idle_after: grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_max_burst();
    int b, gb;
    int exp_src [12];
    logic [7:0] exp_dat [12];
    do_reset();
    b = log_n;
    gb = gn;
    for (int i = 0; i < 20; i++) begin
      load(1, 8'(8'h30 + i));
      load(3, 8'(8'h50 + i));
    end
    for (int i = 0; i < 12; i++) begin
      exp_src[i] = (i >= 4 && i < 8) ? 3 : 1;
      exp_dat[i] = (i < 4) ? 8'(8'h30 + i) : (i < 8) ? 8'(8'h50 + i - 4) : 8'(8'h34 + i - 8);
    end
    for (int k = 0; k < 400 && log_n < b + 12; k++) tick();
    n_checks++;
    if (log_n < b + 12) begin
      n_fail++;
      $display("FAIL burst_timeout: got %0d writes want 12", log_n - b);
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (log_src[b+i] !== exp_src[i] || log_data[b+i] !== exp_dat[i]) begin
        n_fail++;
        $display("FAIL burst_byte%0d: got %h from %0d want %h from %0d",
                 i, log_data[b+i], log_src[b+i], exp_dat[i], exp_src[i]);
      end
    end
    n_checks++;
    if (glog[gb] !== 4'b0010 || glog[gb+1] !== 4'b1000 || glog[gb+2] !== 4'b0010) begin
      n_fail++;
      $display("FAIL burst_grants: got %b,%b,%b want 0010,1000,0010", glog[gb], glog[gb+1], glog[gb+2]);
    end
    n_checks++;
    if (log_grant[b+2] !== 4'b0010 || log_grant[b+3] !== 4'b0000 || log_grant[b+7] !== 4'b0000) begin
      n_fail++;
      $display("FAIL burst_release_on_last: grant at wr 3/4/8 %b/%b/%b want 0010/0000/0000",
               log_grant[b+2], log_grant[b+3], log_grant[b+7]);
    end
  endtask

  task automatic test_idle_timeout();
    int b, gb, rb;
    do_reset();
    b = log_n;
    gb = gn;
    rb = rn;
    load(2, 8'h55);
    for (int k = 0; k < 10 && grant !== 4'b0100; k++) tick();
    load(0, 8'h66);
    for (int k = 0; k < 60 && gn < gb + 2; k++) tick();
    n_checks++;
    if (gn < gb + 2 || rn < rb + 1 || log_n < b + 1) begin
      n_fail++;
      $display("FAIL timeout_events: grants=%0d releases=%0d writes=%0d want >=2/1/1", gn - gb, rn - rb, log_n - b);
    end
    n_checks++;
    if (log_src[b] !== 2 || log_data[b] !== 8'h55) begin
      n_fail++;
      $display("FAIL timeout_byte: got %h from %0d want 55 from 2", log_data[b], log_src[b]);
    end
    n_checks++;
    if (rcyc[rb] - log_cyc[b] !== IDLE_TO) begin
      n_fail++;
      $display("FAIL timeout_stall_len: release %0d cycles after wr want %0d", rcyc[rb] - log_cyc[b], IDLE_TO);
    end
    n_checks++;
    if (glog[gb] !== 4'b0100 || glog[gb+1] !== 4'b0001 || gcyc[gb+1] - rcyc[rb] !== 1) begin
      n_fail++;
      $display("FAIL timeout_next_grant: got %b then %b after %0d cycles want 0100 then 0001 after 1",
               glog[gb], glog[gb+1], gcyc[gb+1] - rcyc[rb]);
    end
  endtask

  task automatic test_tx_full();
    int b, c, viol;
    viol = 0;
    do_reset();
    empty_hold = 1'b1;
    load(0, 8'h61);
    for (int k = 0; k < 10 && grant !== 4'b0001; k++) tick();
    b = log_n;
    repeat (500) begin
      tick();
      if (grant !== 4'b0001 || req_ready !== '0) viol++;
    end
    n_checks++;
    if (log_n !== b || viol !== 0) begin
      n_fail++;
      $display("FAIL full_hold: writes=%0d grant/ready violations=%0d want 0/0", log_n - b, viol);
    end
    empty_hold = 1'b0;
    c = cyc;
    for (int k = 0; k < 10 && log_n == b; k++) tick();
    n_checks++;
    if (log_n == b || log_cyc[b] !== c + 1 || log_data[b] !== 8'h61) begin
      n_fail++;
      $display("FAIL full_resume: wr at +%0d data %h want +1 data 61", log_cyc[b] - c, log_data[b]);
    end
  endtask

  task automatic test_back_to_back();
    int b, s, cons0, bad0, sb_err;
    int sb_start [NREQ];
    int sb_cnt [NREQ];
    do_reset();
    b = log_n;
    cons0 = consec;
    bad0 = bad_rdy;
    sb_err = 0;
    for (int i = 0; i < NREQ; i++) begin
      sb_start[i] = src_len[i];
      sb_cnt[i] = 0;
      for (int j = 0; j < 250; j++) load(i, 8'($urandom_range(0, 255)));
    end
    gaps = 1'b1;
    for (int k = 0; k < 40000 && log_n < b + 1000; k++) tick();
    gaps = 1'b0;
    n_checks++;
    if (log_n - b !== 1000) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d bytes want 1000", log_n - b);
    end
    for (int i = b; i < log_n; i++) begin
      s = log_src[i];
      n_checks++;
      if (s < 0 || s >= NREQ) begin
        n_fail++;
        $display("FAIL b2b_src: entry %0d has no single ready", i - b);
      end else if (sb_cnt[s] >= 250 || log_data[i] !== src_mem[s][sb_start[s] + sb_cnt[s]]) begin
        n_fail++;
        $display("FAIL b2b_data: entry %0d req %0d got %h want %h", i - b, s, log_data[i],
                 src_mem[s][(sb_start[s] + sb_cnt[s]) % 1024]);
        sb_cnt[s]++;
      end else begin
        sb_cnt[s]++;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      n_checks++;
      if (sb_cnt[i] !== 250) begin
        n_fail++;
        $display("FAIL b2b_per_req%0d: got %0d bytes want 250", i, sb_cnt[i]);
      end
    end
    n_checks++;
    if (consec - cons0 !== 0 || bad_rdy - bad0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: consecutive wr=%0d bad ready=%0d want 0/0", consec - cons0, bad_rdy - bad0);
    end
    n_checks++;
    if (consec !== 0 || bad_rdy !== 0) begin
      n_fail++;
      $display("FAIL whole_run_pulses: consecutive wr=%0d bad ready=%0d want 0/0", consec, bad_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_message();
    test_max_burst();
    test_idle_timeout();
    test_tx_full();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
